rc4_key_search_ctrl: RTL and testbench

- Parametrised key-search sequencer for the RC4 brute-force cracker.
- Walks a programmable key range [key_lo, key_hi] and hands keys to NUM_CORES decrypt/check cores.
- Tracks which cores are busy and stops on the first confirmed match or on range exhaustion.
- Sits between the top-level control (start/abort, result LEDs/HEX) and the replicated decrypt/checker pipelines.

---
 rtl/rc4_search_pkg.sv | 26 ++
 rtl/rc4_core_slot.sv | 35 +++
 rtl/rc4_key_search_ctrl.sv | 122 ++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_search_pkg.sv
// rc4_search_pkg: shared types, defaults and priority helper for the RC4 key-search controller
// Provides the FSM state type, default key/search widths, the core-count ceiling,
// and a lowest-set-bit encoder used by both dispatch and match priority.
package rc4_search_pkg;

    localparam int KEY_WIDTH_DEF   = 24;
    localparam int SEARCH_BITS_DEF = 22;
    localparam int MAX_CORES       = 16;
    localparam int IDX_W           = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_FOUND     = 3'd3,
        ST_EXHAUSTED = 3'd4
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set (callers qualify with |v).
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [MAX_CORES-1:0] v);
        lowest_idx = '0;
        for (int i = MAX_CORES - 1; i >= 0; i--)
            if (v[i]) lowest_idx = IDX_W'(i);
    endfunction

endpackage

// File: rtl/rc4_core_slot.sv
// rc4_core_slot: per-core busy flag and key register for one decrypt core
// Ports: clk/rst clock and sync reset; clr drops the busy flag (abort or new search);
// load dispatches key_in to this core; done is a busy-qualified completion pulse;
// busy is the slot occupancy flag; core_start/core_key drive the attached core.
module rc4_core_slot #(
    parameter int KEY_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 load,
    input  logic                 done,
    input  logic [KEY_WIDTH-1:0] key_in,
    output logic                 busy,
    output logic                 core_start,
    output logic [KEY_WIDTH-1:0] core_key
);

    logic [KEY_WIDTH-1:0] key_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            key_r <= '0;
        end else begin
            busy <= clr ? 1'b0 : load ? 1'b1 : done ? 1'b0 : busy;
            if (load) key_r <= key_in;
        end
    end

    // The key is forwarded during the dispatch cycle so it is valid alongside core_start.
    assign core_start = load;
    assign core_key   = load ? key_in : key_r;

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl: walks a key range and hands keys to NUM_CORES RC4 decrypt/check cores
// Ports: clk/rst clock and sync active-high reset; start/abort control pulses;
// key_lo/key_hi inclusive search range; core_key/core_start per-core key and dispatch pulse;
// core_done/core_match per-core completion and result; busy/found/exhausted status;
// found_key matching key; keys_tried count of accepted completions in this search.
module rc4_key_search_ctrl
    import rc4_search_pkg::*;
#(
    parameter int KEY_WIDTH   = KEY_WIDTH_DEF,
    parameter int SEARCH_BITS = SEARCH_BITS_DEF,
    parameter int NUM_CORES   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [SEARCH_BITS-1:0]         key_lo,
    input  logic [SEARCH_BITS-1:0]         key_hi,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic [NUM_CORES-1:0]           core_start,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_match,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [SEARCH_BITS:0]           keys_tried
);

    state_t                 state;
    logic [SEARCH_BITS-1:0] lo_r, hi_r, next_key;
    logic [NUM_CORES-1:0]   slot_busy, free, done_v, match_v, load;
    logic [IDX_W-1:0]       disp_idx, match_idx;
    logic [KEY_WIDTH-1:0]   match_key, issue_key;
    logic [SEARCH_BITS:0]   done_cnt;
    logic                   running, accept, clr, match_any, dispatch, last;

    assign running   = (state == ST_RUN) || (state == ST_DRAIN);
    assign accept    = start && !abort && !running;
    assign clr       = abort || accept;
    assign busy      = running;
    // Completions only count for cores we actually dispatched to in this search.
    assign done_v    = core_done & slot_busy & {NUM_CORES{running}};
    assign match_v   = done_v & core_match;
    assign match_any = |match_v;
    assign free      = ~slot_busy;
    assign disp_idx  = lowest_idx(MAX_CORES'(free));
    assign match_idx = lowest_idx(MAX_CORES'(match_v));
    // An inverted range never dispatches; the RUN state retires it on its first cycle.
    assign dispatch  = (state == ST_RUN) && !abort && !match_any && (|free) && (lo_r <= hi_r);
    assign last      = next_key == hi_r;
    assign issue_key = KEY_WIDTH'(next_key);

    always_comb begin
        load      = '0;
        match_key = '0;
        done_cnt  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            load[i]   = dispatch && (disp_idx == IDX_W'(i));
            match_key = (match_idx == IDX_W'(i)) ? core_key[i*KEY_WIDTH +: KEY_WIDTH] : match_key;
            done_cnt  = done_cnt + (SEARCH_BITS+1)'(done_v[i]);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CORES; g++) begin : g_slot
            rc4_core_slot #(.KEY_WIDTH(KEY_WIDTH)) u_slot (
                .clk        (clk),
                .rst        (rst),
                .clr        (clr),
                .load       (load[g]),
                .done       (done_v[g]),
                .key_in     (issue_key),
                .busy       (slot_busy[g]),
                .core_start (core_start[g]),
                .core_key   (core_key[g*KEY_WIDTH +: KEY_WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lo_r       <= '0;
            hi_r       <= '0;
            next_key   <= '0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            found_key  <= '0;
            keys_tried <= '0;
        end else if (abort) begin
            state     <= ST_IDLE;
            found     <= 1'b0;
            exhausted <= 1'b0;
        end else if (accept) begin
            state      <= ST_RUN;
            lo_r       <= key_lo;
            hi_r       <= key_hi;
            next_key   <= key_lo;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            found_key  <= '0;
            keys_tried <= '0;
        end else if (running) begin
            keys_tried <= keys_tried + done_cnt;
            if (match_any) begin
                found_key <= match_key;
                found     <= 1'b1;
                state     <= ST_FOUND;
            end else if ((state == ST_RUN && lo_r > hi_r) || (state == ST_DRAIN && slot_busy == '0)) begin
                exhausted <= 1'b1;
                state     <= ST_EXHAUSTED;
            end else if (dispatch) begin
                // Holding next_key on the final key keeps a full-range search from wrapping.
                next_key <= last ? next_key : next_key + 1'b1;
                state    <= last ? ST_DRAIN : ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// tb_rc4_key_search_ctrl: directed self-checking bench for rc4_key_search_ctrl
module tb_rc4_key_search_ctrl;

    localparam int KW = 24;
    localparam int SB = 22;
    localparam int NC = 4;

    logic             clk = 1'b0;
    logic             rst, start, abort;
    logic [SB-1:0]    key_lo, key_hi;
    logic [NC*KW-1:0] core_key;
    logic [NC-1:0]    core_start, core_done, core_match;
    logic [NC-1:0]    auto_done = '0, auto_match = '0, man_done = '0, man_match = '0;
    logic             busy, found, exhausted;
    logic [KW-1:0]    found_key;
    logic [SB:0]      keys_tried;

    int            checks = 0;
    int            failures = 0;
    int            post_found = 0;
    int            lat = 5;
    logic          auto_en = 1'b0;
    logic          match_en = 1'b0;
    logic [KW-1:0] match_key = '0;
    int            cnt [NC];
    logic [KW-1:0] mkey [NC];
    logic [KW-1:0] issued [$];

    assign core_done  = auto_done | man_done;
    assign core_match = auto_match | man_match;

    always #5 clk = ~clk;

    rc4_key_search_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .key_lo     (key_lo),
        .key_hi     (key_hi),
        .core_key   (core_key),
        .core_start (core_start),
        .core_done  (core_done),
        .core_match (core_match),
        .busy       (busy),
        .found      (found),
        .exhausted  (exhausted),
        .found_key  (found_key),
        .keys_tried (keys_tried)
    );

    initial for (int i = 0; i < NC; i++) begin
        cnt[i]  = 0;
        mkey[i] = '0;
    end

    // Core model: fixed-latency cores; done pulses driven just after the edge, starts sampled mid-cycle.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            auto_done[i]  = 1'b0;
            auto_match[i] = 1'b0;
            if (auto_en && cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    auto_done[i]  = 1'b1;
                    auto_match[i] = match_en && (mkey[i] == match_key);
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < NC; i++) if (core_start[i]) begin
            mkey[i] = core_key[i*KW +: KW];
            if (auto_en) cnt[i] = lat;
            issued.push_back(mkey[i]);
            if (found) post_found++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_search(input logic [SB-1:0] lo, input logic [SB-1:0] hi);
        key_lo = lo;
        key_hi = hi;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!(found || exhausted) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(n < budget), 64'd1);
    endtask

    initial begin
        int n0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; key_lo = '0; key_hi = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_found", 64'(found), 64'd0);
        chk("rst_exhausted", 64'(exhausted), 64'd0);
        chk("rst_found_key", 64'(found_key), 64'd0);
        chk("rst_keys_tried", 64'(keys_tried), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_core_key", 64'(core_key), 64'd0);

        // 0..9, no match
        auto_en = 1'b1;
        issued.delete();
        start_search(22'd0, 22'd9);
        chk("t1_first_start", 64'(core_start), 64'd1);
        chk("t1_first_key", 64'(core_key[KW-1:0]), 64'd0);
        wait_end("t1_timeout", 300);
        step();
        chk("t1_count", 64'(issued.size()), 64'd10);
        for (int i = 0; i < 10 && i < issued.size(); i++) chk("t1_key", 64'(issued[i]), 64'(i));
        chk("t1_exhausted", 64'(exhausted), 64'd1);
        chk("t1_found", 64'(found), 64'd0);
        chk("t1_keys_tried", 64'(keys_tried), 64'd10);
        chk("t1_busy", 64'(busy), 64'd0);

        // 0x100..0x1FF, match at 0x123
        match_en = 1'b1;
        match_key = 24'h000123;
        issued.delete();
        start_search(22'h100, 22'h1FF);
        wait_end("t2_timeout", 500);
        n0 = issued.size();
        chk("t2_found", 64'(found), 64'd1);
        chk("t2_found_key", 64'(found_key), 64'h000123);
        chk("t2_busy", 64'(busy), 64'd0);
        chk("t2_exhausted", 64'(exhausted), 64'd0);
        repeat (20) step();
        chk("t2_no_start_after", 64'(issued.size()), 64'(n0));
        match_en = 1'b0;

        // simultaneous matches on core1 (0x20) and core3 (0x22)
        auto_en = 1'b0;
        start_search(22'h1F, 22'h30);
        repeat (4) step();
        chk("t3_core1_key", 64'(core_key[KW +: KW]), 64'h20);
        chk("t3_core3_key", 64'(core_key[3*KW +: KW]), 64'h22);
        man_done = 4'b1010;
        man_match = 4'b1010;
        step();
        man_done = '0;
        man_match = '0;
        chk("t3_found", 64'(found), 64'd1);
        chk("t3_found_key", 64'(found_key), 64'h000020);

        // top-of-range single key, no wrap
        auto_en = 1'b1;
        issued.delete();
        start_search(22'h3FFFFF, 22'h3FFFFF);
        wait_end("t4_timeout", 100);
        repeat (5) step();
        chk("t4_count", 64'(issued.size()), 64'd1);
        if (issued.size() > 0) chk("t4_key", 64'(issued[0]), 64'h3FFFFF);
        chk("t4_exhausted", 64'(exhausted), 64'd1);
        chk("t4_keys_tried", 64'(keys_tried), 64'd1);
        chk("t4_found", 64'(found), 64'd0);

        // inverted range
        issued.delete();
        start_search(22'd5, 22'd4);
        chk("t5_exh_early", 64'(exhausted), 64'd0);
        step();
        chk("t5_exhausted", 64'(exhausted), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_count", 64'(issued.size()), 64'd0);

        // abort with 3 busy cores, stale dones, then a fresh search
        auto_en = 1'b0;
        issued.delete();
        start_search(22'd0, 22'h100);
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_busy_after_abort", 64'(busy), 64'd0);
        step();
        chk("t6_dispatched", 64'(issued.size()), 64'd3);
        man_done = 4'b0111;
        man_match = 4'b0111;
        step();
        man_done = '0;
        man_match = '0;
        step();
        chk("t6_stale_found", 64'(found), 64'd0);
        chk("t6_stale_tried", 64'(keys_tried), 64'd0);
        auto_en = 1'b1;
        issued.delete();
        start_search(22'd0, 22'd3);
        wait_end("t6_timeout", 100);
        chk("t6_count", 64'(issued.size()), 64'd4);
        for (int i = 0; i < 4 && i < issued.size(); i++) chk("t6_key", 64'(issued[i]), 64'(i));
        chk("t6_keys_tried", 64'(keys_tried), 64'd4);
        chk("t6_exhausted", 64'(exhausted), 64'd1);
        chk("post_found_starts", 64'(post_found), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
